// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-cache / memory miss sequencing path.
package mips_mem_pkg;

    localparam int unsigned LAT_W = $clog2(16);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WB_WAIT = 2'd1,
        RF_WAIT = 2'd2,
        FILL    = 2'd3
    } cms_state_t;

    localparam logic CACHE_IN_MEM = 1'b0;
    localparam logic CACHE_IN_REG = 1'b1;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that times the fixed data-memory access latency.
module mem_latency_counter
    import mips_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_value_i,
    output logic [LAT_W-1:0] count_o,
    output logic             zero_o
);

    logic [LAT_W-1:0] count_q;

    // Free-runs down to zero and parks there until the next load.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - LAT_W'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/cache_miss_sequencer.sv
// Load/store sequencer for the data cache: hit completion, dirty write-back,
// line refill, PC stall generation and miss/write-back performance counters.
module cache_miss_sequencer
    import mips_mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic             cache_hit,
    input  logic             cache_dirty,
    input  logic [31:0]      victim_addr,
    output logic             stall,
    output logic             done,
    output logic             we_cache,
    output logic             cache_input_type,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             mem_write_en,
    output logic [31:0]      mem_addr,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    // The refill read begins on the cycle its address is first presented and
    // FILL is its last cycle, so RF_WAIT covers MEM_LATENCY-1 cycles (none at 1).
    localparam logic [LAT_W-1:0] WB_LOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic [LAT_W-1:0] RF_LOAD = (MEM_LATENCY > 1) ? LAT_W'(MEM_LATENCY - 2) : '0;
    localparam bit               SKIP_RF = (MEM_LATENCY == 1);

    cms_state_t       state_q, state_d;
    logic [31:0]      fill_addr_q, fill_addr_d;
    logic [31:0]      wb_addr_q, wb_addr_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
    logic             cnt_load;
    logic [LAT_W-1:0] cnt_load_value;
    logic [LAT_W-1:0] cnt_value;
    logic             cnt_zero;

    mem_latency_counter u_lat_cnt (
        .clk          (clk),
        .rst_b        (rst_b),
        .load_i       (cnt_load),
        .load_value_i (cnt_load_value),
        .count_o      (cnt_value),
        .zero_o       (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            wb_addr_q   <= wb_addr_d;
            miss_cnt_q  <= miss_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        fill_addr_d      = fill_addr_q;
        wb_addr_d        = wb_addr_q;
        miss_cnt_d       = miss_cnt_q;
        wb_cnt_d         = wb_cnt_q;
        cnt_load         = 1'b0;
        cnt_load_value   = '0;
        stall            = 1'b0;
        done             = 1'b0;
        we_cache         = 1'b0;
        cache_input_type = CACHE_IN_MEM;
        set_valid        = 1'b0;
        set_dirty        = 1'b0;
        mem_write_en     = 1'b0;
        mem_addr         = req_addr;

        unique case (state_q)
            IDLE: begin
                if (req_valid && cache_hit) begin
                    done = 1'b1;
                    if (req_write) begin
                        we_cache         = 1'b1;
                        cache_input_type = CACHE_IN_REG;
                        set_valid        = 1'b1;
                        set_dirty        = 1'b1;
                    end
                end else if (req_valid) begin
                    stall       = 1'b1;
                    fill_addr_d = req_addr;
                    miss_cnt_d  = miss_cnt_q + CNT_W'(1);
                    cnt_load    = 1'b1;
                    if (cache_dirty) begin
                        wb_addr_d      = victim_addr;
                        wb_cnt_d       = wb_cnt_q + CNT_W'(1);
                        cnt_load_value = WB_LOAD;
                        state_d        = WB_WAIT;
                    end else begin
                        cnt_load_value = RF_LOAD;
                        state_d        = SKIP_RF ? FILL : RF_WAIT;
                    end
                end
            end
            WB_WAIT: begin
                stall            = 1'b1;
                mem_addr         = wb_addr_q;
                cache_input_type = CACHE_IN_REG;
                // Counter still holds its load value only on the first cycle.
                mem_write_en     = (cnt_value == WB_LOAD);
                if (cnt_zero) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = RF_LOAD;
                    state_d        = SKIP_RF ? FILL : RF_WAIT;
                end
            end
            RF_WAIT: begin
                stall    = 1'b1;
                mem_addr = fill_addr_q;
                if (cnt_zero) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                stall            = 1'b1;
                mem_addr         = fill_addr_q;
                we_cache         = 1'b1;
                cache_input_type = CACHE_IN_MEM;
                set_valid        = 1'b1;
                set_dirty        = 1'b0;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed bench: one sequencer at MEM_LATENCY=4 and one at MEM_LATENCY=1 on shared stimulus.
module tb_cache_miss_sequencer;

    logic        clk;
    logic        rst_b;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic        cache_hit;
    logic        cache_dirty;
    logic [31:0] victim_addr;

    logic        stall, done, we_cache, cache_input_type, set_valid, set_dirty, mem_write_en;
    logic [31:0] mem_addr, miss_count, wb_count;

    logic        stall1, done1, we_cache1, cache_input_type1, set_valid1, set_dirty1, mem_write_en1;
    logic [31:0] mem_addr1, miss_count1, wb_count1;

    int n_checks = 0;
    int n_errors = 0;

    cache_miss_sequencer #(.MEM_LATENCY(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
        .victim_addr(victim_addr), .stall(stall), .done(done), .we_cache(we_cache),
        .cache_input_type(cache_input_type), .set_valid(set_valid), .set_dirty(set_dirty),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    cache_miss_sequencer #(.MEM_LATENCY(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
        .victim_addr(victim_addr), .stall(stall1), .done(done1), .we_cache(we_cache1),
        .cache_input_type(cache_input_type1), .set_valid(set_valid1), .set_dirty(set_dirty1),
        .mem_write_en(mem_write_en1), .mem_addr(mem_addr1), .miss_count(miss_count1),
        .wb_count(wb_count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Follows a miss on the latency-4 instance until stall drops; bounded at 40 cycles.
    task automatic run_miss(input logic drop_valid, input logic [31:0] fill_a, input logic [31:0] wb_a,
                            output int stall_cyc, output int mwe_cyc, output logic [31:0] mwe_addr,
                            output int fill_cyc, output int fa_cyc, output int wa_cyc, output int overlap);
        stall_cyc = 0; mwe_cyc = 0; mwe_addr = '0; fill_cyc = 0; fa_cyc = 0; wa_cyc = 0; overlap = 0;
        while (stall && stall_cyc < 40) begin
            stall_cyc++;
            if (mem_write_en) begin
                mwe_cyc++;
                mwe_addr = mem_addr;
            end
            if (we_cache && cache_input_type == 1'b0 && set_valid && !set_dirty && mem_addr == fill_a)
                fill_cyc++;
            if (mem_addr == fill_a) fa_cyc++;
            if (mem_addr == wb_a) wa_cyc++;
            if ((we_cache && mem_write_en) || (we_cache && done)) overlap++;
            @(negedge clk);
            if (drop_valid) req_valid = 1'b0;
            else            cache_hit = 1'b1;
            #1;
        end
    endtask

    initial begin
        int          st, mwe, fc, fa, wa, ov;
        logic [31:0] mwa;

        rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        cache_hit = 1'b0; cache_dirty = 1'b0; victim_addr = '0;
        #2;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_strobes", 32'({we_cache, mem_write_en, set_valid}), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_miss_count", miss_count, 32'd0);
        check_eq("rst_wb_count", wb_count, 32'd0);
        @(negedge clk); rst_b = 1'b1;

        // Load hit completes with no stall
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; cache_hit = 1'b1; #1;
        check_eq("hit_ld_done", 32'(done), 32'd1);
        check_eq("hit_ld_stall", 32'(stall), 32'd0);
        check_eq("hit_ld_strobes", 32'({we_cache, mem_write_en}), 32'd0);
        check_eq("hit_ld_mem_addr", mem_addr, 32'h40);

        // Clean load miss: IDLE + 3 RF_WAIT + FILL
        @(negedge clk);
        req_addr = 32'h80; cache_hit = 1'b0; cache_dirty = 1'b0; #1;
        run_miss(1'b0, 32'h80, 32'hFFFF_FFFF, st, mwe, mwa, fc, fa, wa, ov);
        check_eq("clean_stall_cycles", 32'(st), 32'd5);
        check_eq("clean_mem_we_cycles", 32'(mwe), 32'd0);
        check_eq("clean_fill_cycles", 32'(fc), 32'd1);
        check_eq("clean_fill_addr_cycles", 32'(fa), 32'd5);
        check_eq("clean_replay_done", 32'(done), 32'd1);
        check_eq("clean_replay_stall", 32'(stall), 32'd0);
        check_eq("clean_miss_count", miss_count, 32'd1);
        check_eq("clean_wb_count", wb_count, 32'd0);

        // Dirty store miss: IDLE + 4 WB_WAIT + 3 RF_WAIT + FILL, then store-merge replay
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h200; cache_hit = 1'b0; cache_dirty = 1'b1;
        victim_addr = 32'h100; #1;
        run_miss(1'b0, 32'h200, 32'h100, st, mwe, mwa, fc, fa, wa, ov);
        check_eq("dirty_stall_cycles", 32'(st), 32'd9);
        check_eq("dirty_mem_we_cycles", 32'(mwe), 32'd1);
        check_eq("dirty_mem_we_addr", mwa, 32'h100);
        check_eq("dirty_wb_addr_cycles", 32'(wa), 32'd4);
        check_eq("dirty_fill_addr_cycles", 32'(fa), 32'd5);
        check_eq("dirty_fill_cycles", 32'(fc), 32'd1);
        check_eq("dirty_overlap", 32'(ov), 32'd0);
        check_eq("dirty_replay", 32'({we_cache, cache_input_type, set_valid, set_dirty, done, stall}),
                 32'b111110);
        check_eq("dirty_wb_count", wb_count, 32'd1);
        check_eq("dirty_miss_count", miss_count, 32'd2);

        @(negedge clk);
        req_valid = 1'b0; cache_dirty = 1'b0; #1;
        check_eq("idle_outputs", 32'({stall, done, we_cache, mem_write_en}), 32'd0);
        check_eq("idle_mem_addr", mem_addr, 32'h200);

        // Clean miss with req_valid dropped right after it starts: FILL must still happen
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; cache_hit = 1'b0; #1;
        run_miss(1'b1, 32'h300, 32'hFFFF_FFFF, st, mwe, mwa, fc, fa, wa, ov);
        check_eq("drop_stall_cycles", 32'(st), 32'd5);
        check_eq("drop_fill_cycles", 32'(fc), 32'd1);
        check_eq("drop_done", 32'(done), 32'd0);
        check_eq("drop_miss_count", miss_count, 32'd3);

        // MEM_LATENCY=1 dirty store miss: IDLE + WB_WAIT + FILL
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h400; cache_hit = 1'b0;
        cache_dirty = 1'b1; victim_addr = 32'h500; #1;
        st = 0; mwe = 0; mwa = '0; fc = 0; ov = 0;
        while (stall1 && st < 40) begin
            st++;
            if (mem_write_en1) begin
                mwe++;
                mwa = mem_addr1;
            end
            if (we_cache1 && cache_input_type1 == 1'b0 && set_valid1 && !set_dirty1 && mem_addr1 == 32'h400)
                fc++;
            if ((we_cache1 && mem_write_en1) || (we_cache1 && done1)) ov++;
            @(negedge clk); cache_hit = 1'b1; #1;
        end
        check_eq("lat1_stall_cycles", 32'(st), 32'd3);
        check_eq("lat1_mem_we_cycles", 32'(mwe), 32'd1);
        check_eq("lat1_mem_we_addr", mwa, 32'h500);
        check_eq("lat1_fill_cycles", 32'(fc), 32'd1);
        check_eq("lat1_overlap", 32'(ov), 32'd0);
        check_eq("lat1_replay_done", 32'(done1), 32'd1);
        check_eq("lat1_miss_count", miss_count1, 32'd4);
        check_eq("lat1_wb_count", wb_count1, 32'd2);

        // Let the latency-4 instance finish the same dirty miss
        @(negedge clk); req_valid = 1'b0; cache_dirty = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("lat4_settled_stall", 32'(stall), 32'd0);
        check_eq("lat4_miss_count", miss_count, 32'd4);
        check_eq("lat4_wb_count", wb_count, 32'd2);

        // Miss counter wraps from all-ones to zero
        @(negedge clk);
        force u_dut.miss_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.miss_cnt_q;
        #1;
        check_eq("wrap_preload", miss_count, 32'hFFFF_FFFF);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h600; cache_hit = 1'b0; #1;
        run_miss(1'b0, 32'h600, 32'hFFFF_FFFF, st, mwe, mwa, fc, fa, wa, ov);
        check_eq("wrap_stall_cycles", 32'(st), 32'd5);
        check_eq("wrap_miss_count", miss_count, 32'h0);
        check_eq("wrap_wb_count", wb_count, 32'd2);

        // Asynchronous reset in the middle of RF_WAIT
        @(negedge clk);
        req_addr = 32'h700; cache_hit = 1'b0; #1;
        @(negedge clk);
        @(negedge clk);
        #2;
        check_eq("pre_rst_stall", 32'(stall), 32'd1);
        rst_b = 1'b0; req_valid = 1'b0; #1;
        check_eq("async_rst_stall", 32'(stall), 32'd0);
        check_eq("async_rst_strobes", 32'({we_cache, mem_write_en, done}), 32'd0);
        check_eq("async_rst_miss_count", miss_count, 32'd0);
        check_eq("async_rst_miss_count1", miss_count1, 32'd0);
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; cache_hit = 1'b1; #1;
        check_eq("post_rst_hit_done", 32'(done), 32'd1);
        check_eq("post_rst_hit_stall", 32'(stall), 32'd0);

        @(negedge clk); req_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
